// File: rtl/breg_wb_ctrl.sv
// Register-bank write-back controller: sequences each write, stalls the processor
// while memory or the external button is pending, and captures the switch word.
module breg_wb_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int LARG_CONT   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inicio,
  input  logic [2:0]  fonte,
  input  logic [4:0]  reg_destino,
  input  logic        mem_pronto,
  input  logic        botao,
  input  logic [31:0] chaves,
  output logic [2:0]  controle,
  output logic        escreve_breg,
  output logic [4:0]  reg_escrita,
  output logic [31:0] entrada_ext,
  output logic        parada,
  output logic        ocupado,
  output logic        erro,
  output logic [1:0]  estado
);

  typedef enum logic [1:0] {
    OCIOSO       = 2'd0,
    ESPERA_MEM   = 2'd1,
    ESPERA_BOTAO = 2'd2,
    ESCREVE      = 2'd3
  } estado_t;

  localparam logic [LARG_CONT-1:0] LIMITE = LARG_CONT'(MEM_TIMEOUT - 1);

  estado_t              st;
  logic [LARG_CONT-1:0] cont;
  logic                 sinc_a;
  logic                 sinc_b;
  logic                 sinc_ant;
  logic                 borda;

  // Rising edge of the synchronized button; only acted upon in ESPERA_BOTAO.
  assign borda  = sinc_b & ~sinc_ant;
  assign estado = st;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st           <= OCIOSO;
      cont         <= '0;
      sinc_a       <= 1'b0;
      sinc_b       <= 1'b0;
      sinc_ant     <= 1'b0;
      controle     <= 3'd0;
      reg_escrita  <= 5'd0;
      entrada_ext  <= 32'd0;
      escreve_breg <= 1'b0;
      parada       <= 1'b0;
      ocupado      <= 1'b0;
      erro         <= 1'b0;
    end else begin
      sinc_a       <= botao;
      sinc_b       <= sinc_a;
      sinc_ant     <= sinc_b;
      escreve_breg <= 1'b0;
      case (st)
        OCIOSO: begin
          if (inicio) begin
            case (fonte)
              3'd0, 3'd2, 3'd4: begin
                controle     <= fonte;
                reg_escrita  <= reg_destino;
                st           <= ESCREVE;
                escreve_breg <= 1'b1;
                ocupado      <= 1'b1;
              end
              3'd1: begin
                controle    <= fonte;
                reg_escrita <= reg_destino;
                st          <= ESPERA_MEM;
                cont        <= '0;
                parada      <= 1'b1;
                ocupado     <= 1'b1;
              end
              3'd3: begin
                controle    <= fonte;
                reg_escrita <= reg_destino;
                st          <= ESPERA_BOTAO;
                parada      <= 1'b1;
                ocupado     <= 1'b1;
              end
              default: erro <= 1'b1;
            endcase
          end
        end
        ESPERA_MEM: begin
          if (inicio) erro <= 1'b1;
          // A ready memory wins over the timeout in the same cycle.
          if (mem_pronto) begin
            st           <= ESCREVE;
            escreve_breg <= 1'b1;
            parada       <= 1'b0;
          end else if (cont == LIMITE) begin
            st      <= OCIOSO;
            erro    <= 1'b1;
            parada  <= 1'b0;
            ocupado <= 1'b0;
          end else begin
            cont <= cont + LARG_CONT'(1);
          end
        end
        ESPERA_BOTAO: begin
          if (inicio) erro <= 1'b1;
          if (borda) begin
            entrada_ext  <= chaves;
            st           <= ESCREVE;
            escreve_breg <= 1'b1;
            parada       <= 1'b0;
          end
        end
        ESCREVE: begin
          if (inicio) erro <= 1'b1;
          st      <= OCIOSO;
          ocupado <= 1'b0;
        end
        default: st <= OCIOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_breg_wb_ctrl.sv
// Directed bench for breg_wb_ctrl: expected writes (cycle, select, address, word)
// are queued by the driver and matched by a monitor on every escreve_breg pulse.
module tb_breg_wb_ctrl;

  localparam int W = 56;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inicio;
  logic [2:0]  fonte;
  logic [4:0]  reg_destino;
  logic        mem_pronto;
  logic        botao;
  logic [31:0] chaves;
  logic [2:0]  controle;
  logic        escreve_breg;
  logic [4:0]  reg_escrita;
  logic [31:0] entrada_ext;
  logic        parada;
  logic        ocupado;
  logic        erro;
  logic [1:0]  estado;

  logic [15:0]  cyc = 16'd0;
  logic [W-1:0] exp_q[$];
  logic [31:0]  ext_exp;
  int           n_tests = 0;
  int           n_fail  = 0;

  breg_wb_ctrl #(.MEM_TIMEOUT(15), .LARG_CONT(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .inicio       (inicio),
    .fonte        (fonte),
    .reg_destino  (reg_destino),
    .mem_pronto   (mem_pronto),
    .botao        (botao),
    .chaves       (chaves),
    .controle     (controle),
    .escreve_breg (escreve_breg),
    .reg_escrita  (reg_escrita),
    .entrada_ext  (entrada_ext),
    .parada       (parada),
    .ocupado      (ocupado),
    .erro         (erro),
    .estado       (estado)
  );

  // Clock and edge counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 16'd1;

  function automatic logic [W-1:0] pk(input logic [15:0] c, input logic [2:0] ct,
                                      input logic [4:0] r, input logic [31:0] e);
    return {c, ct, r, e};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [W-1:0] a;
    if (escreve_breg === 1'b1) begin
      n_tests++;
      a = pk(cyc, controle, reg_escrita, entrada_ext);
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL write_unexpected: got cyc=%0d ctrl=%0d reg=%0d ext=%0h, expected no write",
                 cyc, controle, reg_escrita, entrada_ext);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          n_fail++;
          $display("FAIL write: got cyc=%0d ctrl=%0d reg=%0d ext=%0h, expected cyc=%0d ctrl=%0d reg=%0d ext=%0h",
                   a[55:40], a[39:37], a[36:32], a[31:0], e[55:40], e[39:37], e[36:32], e[31:0]);
        end
      end
    end
  end

  // Driver tasks (all called at a falling edge)
  task automatic idle(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic issue(input logic [2:0] f, input logic [4:0] d, output logic [15:0] n);
    inicio      = 1'b1;
    fonte       = f;
    reg_destino = d;
    n           = cyc + 16'd1;
    @(negedge clk);
    inicio = 1'b0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n   = 1'b1;
    ext_exp = 32'd0;
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_estado"}, 32'(estado), 32'd0);
    check({nm, "_controle"}, 32'(controle), 32'd0);
    check({nm, "_reg_escrita"}, 32'(reg_escrita), 32'd0);
    check({nm, "_entrada_ext"}, entrada_ext, 32'd0);
    check({nm, "_escreve"}, 32'(escreve_breg), 32'd0);
    check({nm, "_parada"}, 32'(parada), 32'd0);
    check({nm, "_ocupado"}, 32'(ocupado), 32'd0);
    check({nm, "_erro"}, 32'(erro), 32'd0);
  endtask

  initial begin
    logic [15:0] n;
    logic [15:0] m;
    logic [15:0] c;
    rst_n = 1'b0; inicio = 1'b0; fonte = 3'd0; reg_destino = 5'd0;
    mem_pronto = 1'b0; botao = 1'b0; chaves = 32'd0; ext_exp = 32'd0;
    idle(2);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Single-cycle sources, back-to-back every 2 cycles
    issue(3'd0, 5'd7, n);
    exp_q.push_back(pk(n, 3'd0, 5'd7, ext_exp));
    check("alu_parada", 32'(parada), 32'd0);
    check("alu_ocupado", 32'(ocupado), 32'd1);
    idle(1);
    check("alu_idle", 32'(ocupado), 32'd0);
    issue(3'd4, 5'd31, n);
    exp_q.push_back(pk(n, 3'd4, 5'd31, ext_exp));
    idle(1);
    issue(3'd2, 5'd9, n);
    exp_q.push_back(pk(n, 3'd2, 5'd9, ext_exp));
    idle(1);
    check("b2b_erro", 32'(erro), 32'd0);

    // Memory, ready 4 cycles after the request
    issue(3'd1, 5'd3, n);
    exp_q.push_back(pk(n + 16'd4, 3'd1, 5'd3, ext_exp));
    for (int i = 0; i < 4; i++) begin
      check("mem_parada_wait", 32'(parada), 32'd1);
      if (i == 3) mem_pronto = 1'b1;
      @(negedge clk);
    end
    check("mem_parada_write", 32'(parada), 32'd0);
    mem_pronto = 1'b0;
    idle(1);

    // Memory, earliest case: ready already at the first wait edge
    mem_pronto = 1'b1;
    issue(3'd1, 5'd14, n);
    exp_q.push_back(pk(n + 16'd1, 3'd1, 5'd14, ext_exp));
    idle(1);
    mem_pronto = 1'b0;
    idle(1);

    // Ready on the same edge as the timeout count: write wins, no error
    issue(3'd1, 5'd13, n);
    exp_q.push_back(pk(n + 16'd15, 3'd1, 5'd13, ext_exp));
    idle(14);
    mem_pronto = 1'b1;
    @(negedge clk);
    mem_pronto = 1'b0;
    check("mem_race_erro", 32'(erro), 32'd0);
    idle(1);

    // Memory timeout
    issue(3'd1, 5'd12, n);
    idle(14);
    check("tmo_parada_before", 32'(parada), 32'd1);
    check("tmo_erro_before", 32'(erro), 32'd0);
    idle(1);
    check("tmo_erro", 32'(erro), 32'd1);
    check("tmo_parada", 32'(parada), 32'd0);
    check("tmo_ocupado", 32'(ocupado), 32'd0);
    issue(3'd2, 5'd6, n);
    exp_q.push_back(pk(n, 3'd2, 5'd6, ext_exp));
    idle(1);
    check("tmo_erro_sticky", 32'(erro), 32'd1);

    // Button source
    chaves = 32'hDEADBEEF;
    issue(3'd3, 5'd5, n);
    idle(2);
    #2 botao = 1'b1;
    c = cyc;
    exp_q.push_back(pk(c + 16'd3, 3'd3, 5'd5, 32'hDEADBEEF));
    ext_exp = 32'hDEADBEEF;
    idle(5);
    botao = 1'b0;
    idle(1);
    check("btn_ext", entrada_ext, 32'hDEADBEEF);
    check("btn_ocupado", 32'(ocupado), 32'd0);

    // Button pulse while idle must be discarded
    chaves = 32'h12345678;
    botao = 1'b1;
    idle(3);
    botao = 1'b0;
    idle(4);
    check("btn_idle_ext", entrada_ext, 32'hDEADBEEF);
    issue(3'd3, 5'd11, n);
    idle(6);
    check("btn_not_remembered", 32'(parada), 32'd1);
    botao = 1'b1;
    c = cyc;
    exp_q.push_back(pk(c + 16'd3, 3'd3, 5'd11, 32'h12345678));
    ext_exp = 32'h12345678;
    idle(5);
    botao = 1'b0;
    idle(2);

    // Invalid source
    do_reset();
    check("inv_erro_before", 32'(erro), 32'd0);
    issue(3'd6, 5'd1, n);
    check("inv_erro", 32'(erro), 32'd1);
    check("inv_ocupado", 32'(ocupado), 32'd0);
    idle(3);

    // Request while busy in ESPERA_BOTAO
    do_reset();
    issue(3'd3, 5'd4, n);
    idle(1);
    issue(3'd0, 5'd8, m);
    check("busy_erro", 32'(erro), 32'd1);
    check("busy_parada", 32'(parada), 32'd1);
    chaves = 32'hCAFEF00D;
    botao = 1'b1;
    c = cyc;
    exp_q.push_back(pk(c + 16'd3, 3'd3, 5'd4, 32'hCAFEF00D));
    idle(5);
    botao = 1'b0;
    idle(2);

    // Reset in the middle of a memory wait
    issue(3'd1, 5'd2, n);
    idle(3);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ext_exp = 32'd0;
    check_all_zero("midrst");
    mem_pronto = 1'b1;
    idle(4);
    mem_pronto = 1'b0;
    check("midrst_idle", 32'(ocupado), 32'd0);
    idle(2);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
